// File: rtl/rs422_tx_sched_pkg.sv
// rs422_tx_sched_pkg: shared types and defaults for the RS422 transmit scheduler.
// Holds the frame state encoding, default timing constants and the arbiter pick.
// Imported by the interface, tick_gen and the scheduler top.
package rs422_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam int DEF_DIV   = 32;  // 58.9824 MHz / 32 = 1.8432 MHz oversample tick
    localparam int DEF_OVS   = 16;  // 16 ticks per bit -> 115200 baud
    localparam int DATA_BITS = 8;

    // Round-robin pick between two requesters: a lone valid wins outright,
    // on contention the one that was not served last wins.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
        return (v0 & v1) ? ~last : v1;
    endfunction

endpackage

// File: rtl/rs422_tx_sched_if.sv
// rs422_tx_sched_if: the two requester byte handshakes (valid/data/ready each).
// master = requester side (drives valid/data), slave = scheduler side (drives ready).
// ready is a one-cycle acceptance strobe, combinational in the scheduler.
interface rs422_tx_sched_if;
    import rs422_tx_sched_pkg::*;

    logic                 req0_valid;
    logic [DATA_BITS-1:0] req0_data;
    logic                 req0_ready;
    logic                 req1_valid;
    logic [DATA_BITS-1:0] req1_data;
    logic                 req1_ready;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready
    );

endinterface

// File: rtl/rs422_tx_sched_tick_gen.sv
// tick_gen: free-running divider producing a one-cycle oversample tick every DIV clocks.
// Ports: clk59m, rst (async, active-low), tick (high while count == DIV-1).
// First tick falls in the DIV-th cycle after reset release; no backpressure.
module tick_gen
    import rs422_tx_sched_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk59m,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(DIV - 1));

    always_ff @(posedge clk59m or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/rs422_tx_sched.sv
// rs422_tx_sched: two-requester round-robin RS422/UART transmitter (8N1 or 8N2, LSB first).
// Ports: clk59m, rst (async active-low), req (slave handshakes), txd (registered, idle high),
//        busy (frame in progress), grant (owner of current/last frame).
// Frame = (9+STOP_BITS)*OVS*DIV cycles; one byte accepted per frame, only on an IDLE tick.
module rs422_tx_sched
    import rs422_tx_sched_pkg::*;
#(
    parameter int DIV       = DEF_DIV,
    parameter int OVS       = DEF_OVS,
    parameter int STOP_BITS = 1
) (
    input  logic              clk59m,
    input  logic              rst,
    rs422_tx_sched_if.slave   req,
    output logic              txd,
    output logic              busy,
    output logic              grant
);

    // Counter must reach STOP_BITS*OVS-1, at most 2*OVS-1.
    localparam int            CW        = (OVS > 1) ? $clog2(2 * OVS) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(OVS - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * OVS - 1);

    logic                 tick;
    state_t               state, state_nxt;
    logic [CW-1:0]        ovs_cnt, ovs_nxt;
    logic [2:0]           bit_idx, bit_nxt;
    logic [DATA_BITS-1:0] shreg, sh_nxt;
    logic                 grant_nxt;
    logic                 last, last_nxt;
    logic                 txd_nxt;
    logic                 sel;

    tick_gen #(.DIV(DIV)) u_tick (
        .clk59m (clk59m),
        .rst    (rst),
        .tick   (tick)
    );

    always_ff @(posedge clk59m or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            ovs_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            grant   <= 1'b0;
            last    <= 1'b1;  // requester 0 wins the first contention
            txd     <= 1'b1;
        end else begin
            state   <= state_nxt;
            ovs_cnt <= ovs_nxt;
            bit_idx <= bit_nxt;
            shreg   <= sh_nxt;
            grant   <= grant_nxt;
            last    <= last_nxt;
            txd     <= txd_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        ovs_nxt        = ovs_cnt;
        bit_nxt        = bit_idx;
        sh_nxt         = shreg;
        grant_nxt      = grant;
        last_nxt       = last;
        req.req0_ready = 1'b0;
        req.req1_ready = 1'b0;
        sel            = rr_pick(req.req0_valid, req.req1_valid, last);

        case (state)
            ST_IDLE: begin
                if (tick && (req.req0_valid || req.req1_valid)) begin
                    req.req0_ready = ~sel;
                    req.req1_ready = sel;
                    sh_nxt         = sel ? req.req1_data : req.req0_data;
                    grant_nxt      = sel;
                    last_nxt       = sel;
                    ovs_nxt        = '0;
                    state_nxt      = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (ovs_cnt == BIT_LAST) begin
                        ovs_nxt   = '0;
                        bit_nxt   = '0;
                        state_nxt = ST_DATA;
                    end else begin
                        ovs_nxt = ovs_cnt + CW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (ovs_cnt == BIT_LAST) begin
                        ovs_nxt = '0;
                        sh_nxt  = shreg >> 1;
                        bit_nxt = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state_nxt = ST_STOP;
                        end
                    end else begin
                        ovs_nxt = ovs_cnt + CW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (ovs_cnt == STOP_LAST) begin
                        ovs_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        ovs_nxt = ovs_cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Line level is decoded from the next state so the flop changes
        // on the same edge as the state; the line itself never sees a decode.
        case (state_nxt)
            ST_START: txd_nxt = 1'b0;
            ST_DATA:  txd_nxt = sh_nxt[0];
            default:  txd_nxt = 1'b1;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: doc/rs422_tx_sched.md
RS422_TX_SCHED -- requirements
Module: rs422_tx_sched

Interface
REQ-001 SHALL have parameter DIV, default 32: clk59m cycles per oversample tick (58.9824 MHz / 32 = 1.8432 MHz).
REQ-002 SHALL have parameter OVS, default 16: ticks per bit (1.8432 MHz / 16 = 115200 baud).
REQ-003 SHALL have parameter STOP_BITS, default 1, legal values 1 or 2: stop bits per frame.
REQ-004 SHALL have port clk59m, input, 1 bit: system clock, rising-edge active.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req0_valid, input, 1 bit: requester 0 holds a byte.
REQ-007 SHALL have port req0_data, input, 8 bits: requester 0 byte.
REQ-008 SHALL have port req0_ready, output, 1 bit: requester 0 byte accepted this cycle.
REQ-009 SHALL have port req1_valid, input, 1 bit: requester 1 holds a byte.
REQ-010 SHALL have port req1_data, input, 8 bits: requester 1 byte.
REQ-011 SHALL have port req1_ready, output, 1 bit: requester 1 byte accepted this cycle.
REQ-012 SHALL have port txd, output, 1 bit: RS422 serial line, idle high.
REQ-013 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-014 SHALL have port grant, output, 1 bit: index of the requester owning the current or last frame.

Function
REQ-015 SHALL generate an internal 1-cycle tick:
- counter runs 0..DIV-1 and wraps
- tick is asserted when count == DIV-1
- first tick occurs DIV cycles after reset release
REQ-016 SHALL sequence the frame through states IDLE -> START -> DATA -> STOP -> IDLE. All state changes SHALL occur only on tick cycles.
REQ-017 In IDLE, a handshake SHALL occur on a tick cycle when either valid is high.
- reqN_ready = (state==IDLE) & tick & (selected==N) & reqN_valid, combinational
- ready is never high for both requesters in the same cycle
REQ-018 Arbitration SHALL be round-robin with a last-served pointer.
- If only one requester is valid, that requester is selected.
- If both are valid, the requester other than the last served is selected.
- The pointer updates on the handshake.
REQ-019 On the handshake, the block SHALL:
- capture the selected data into an 8-bit shift register
- set grant to the selected index
- enter START
REQ-020 START SHALL drive txd=0 for OVS ticks.
REQ-021 DATA SHALL send 8 bits LSB first, OVS ticks each, using a 3-bit bit index that ends after index 7.
REQ-022 STOP SHALL drive txd=1 for STOP_BITS*OVS ticks, then return to IDLE.
REQ-023 A frame SHALL last (9+STOP_BITS)*OVS*DIV cycles: 5120 cycles with default parameters.
REQ-024 Back-to-back frames SHALL be separated by exactly one extra tick (DIV cycles) of idle-high after STOP.
REQ-025 busy SHALL equal (state != IDLE).
REQ-026 A valid deasserted before its handshake SHALL be ignored. A valid held high SHALL be served no later than after one frame of the other requester.
REQ-027 Input data SHALL be sampled only at the handshake. Changes to data while busy SHALL not affect the frame.
REQ-028 txd SHALL be registered, with no glitches.

Reset
REQ-029 While rst=0, the block SHALL hold:
- txd=1, busy=0, grant=0
- req0_ready=0, req1_ready=0
- state=IDLE, tick counter=0
- last-served pointer=1, so requester 0 wins the first contention
REQ-030 Reset asserted mid-frame SHALL abandon the frame immediately, with txd returning high asynchronously. After release, no partial frame SHALL be resumed.

Structure
REQ-031 A shared package SHALL hold:
- state encoding IDLE/START/DATA/STOP
- default constants DIV=32, OVS=16, DATA_BITS=8
REQ-032 Tick generation SHALL be a sub-module named tick_gen (parameter DIV; ports clk59m, rst, tick). The FSM, arbiter and shifter SHALL remain in rs422_tx_sched.

Verification
REQ-033 Single byte: req0_valid=1 with 8'hA5 -> req0_ready pulses once on a tick; txd = 0,1,0,1,0,0,1,0,1,1, each bit 512 cycles; busy high for 5120 cycles.
REQ-034 Contention: both valid from reset, req0=8'h55, req1=8'hAA -> 8'h55 sent first with grant=0, then 8'hAA with grant=1; inter-frame idle gap of 32 cycles.
REQ-035 Fairness: both valid held for 4 frames -> grant sequence 0,1,0,1; no requester is served twice consecutively.
REQ-036 Mid-frame reset: assert rst during DATA bit 3 -> txd=1 and busy=0 immediately; after release, no output until a new valid is presented.
REQ-037 STOP_BITS=2, byte 8'h00 -> frame of 11 bits, 5632 cycles, txd high for the final 1024 cycles.
REQ-038 Data change: req1_data changed while busy -> transmitted byte equals the value at the handshake.
